// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART core.
//   tx_state_t / rx_state_t : serial FSM state encodings
//   uart_div()              : system clocks per oversampling tick
// Optional parity support is selected with the UART_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // round(clk_hz / (baud * oversample)), never below 1
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned denom;
    int unsigned d;
    denom = baud * oversample;
    d     = (clk_hz + denom / 2) / denom;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: host-side byte interface of the UART.
//   tx_data/tx_valid/tx_ready : transmit push (transfer on valid & ready)
//   rx_data/rx_valid/rx_ready : receive FIFO pop (show-ahead head)
//   rx_frame_err/rx_overrun   : one-cycle receive error pulses
//   parity_odd/rx_parity_err  : only with UART_PARITY_EN
// master = host side, slave = UART side.
interface uart_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_overrun;
`ifdef UART_PARITY_EN
  logic                 parity_odd;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid, rx_ready, parity_odd,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_parity_err
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready, parity_odd,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_parity_err
  );
`else
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO for received frames.
//   i_push/i_data : write request from the RX FSM
//   i_pop         : pop request (ignored while empty)
//   o_data        : head entry, o_valid : not empty
//   o_overrun     : one-cycle pulse when a push is dropped because full
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_overrun
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_valid;
  logic                 r_overrun;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;

  // A push into a full FIFO still lands if the head is popped the same cycle
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop && r_valid;
  assign w_push = i_push && (!w_full || w_pop);

  always_comb begin
    w_count = r_count;
    if (w_push && !w_pop)      w_count = r_count + CW'(1);
    else if (!w_push && w_pop) w_count = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_count;
      r_valid   <= (w_count != '0);
      r_overrun <= i_push && w_full && !w_pop;
    end
  end

  assign o_data    = r_mem[r_rd_ptr];
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with oversampling tick,
// glitch-filtered receiver, framing check and receive FIFO.
//   clk, rst : system clock, asynchronous active-low reset
//   rx       : serial input (asynchronous), tx : serial output, idle high
//   bus      : uart_if.slave host byte interface
// UART_PARITY_EN adds a parity bit to both directions.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned RX_FIFO_DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rx,
  output logic   tx,
  uart_if.slave  bus
);
  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  // Oversampling tick generator
  logic [DIV_W-1:0] r_tick_cnt;
  logic             w_tick;

  assign w_tick = (r_tick_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + DIV_W'(1);
  end

  // Transmit FSM
  tx_state_t            r_tx_state, w_tx_state;
  logic [OS_W-1:0]      r_tx_os, w_tx_os;
  logic [BIT_W-1:0]     r_tx_bit, w_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic                 r_tx, w_tx;
  logic                 r_tx_ready, w_tx_ready;
  logic                 w_tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 r_tx_par, w_tx_par;
`endif

  assign w_tx_bit_end = w_tick && (r_tx_os == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_os    = r_tx_os;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx       = r_tx;
`ifdef UART_PARITY_EN
    w_tx_par   = r_tx_par;
`endif
    if (w_tick) w_tx_os = r_tx_os + OS_W'(1);
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_os = '0;
        w_tx    = 1'b1;
        if (bus.tx_valid) begin
          w_tx_state = TX_START;
          w_tx_shift = bus.tx_data;
          w_tx_bit   = '0;
          w_tx       = 1'b0;
`ifdef UART_PARITY_EN
          w_tx_par   = (^bus.tx_data) ^ bus.parity_odd;
`endif
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_os    = '0;
          w_tx_state = TX_DATA;
          w_tx       = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_os = '0;
          if (r_tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_tx_state = TX_PARITY;
            w_tx       = r_tx_par;
`else
            w_tx_state = TX_STOP;
            w_tx       = 1'b1;
`endif
          end else begin
            w_tx_shift = {1'b0, r_tx_shift[DATA_BITS-1:1]};
            w_tx_bit   = r_tx_bit + BIT_W'(1);
            w_tx       = r_tx_shift[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_os    = '0;
          w_tx_state = TX_STOP;
          w_tx       = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_os    = '0;
          w_tx_state = TX_IDLE;
          w_tx       = 1'b1;
        end
      end
      default: begin
        w_tx_state = TX_IDLE;
        w_tx       = 1'b1;
      end
    endcase
    w_tx_ready = (w_tx_state == TX_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_os    <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_os    <= w_tx_os;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx       <= w_tx;
      r_tx_ready <= w_tx_ready;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par;
`endif
    end
  end

  assign tx           = r_tx;
  assign bus.tx_ready = r_tx_ready;

  // RX input synchroniser; resets to the idle line level
  logic r_rx_meta, r_rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM
  rx_state_t            r_rx_state, w_rx_state;
  logic [OS_W-1:0]      r_rx_os, w_rx_os;
  logic [BIT_W-1:0]     r_rx_bit, w_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
  logic                 r_frame_err, w_frame_err;
  logic                 w_push;
  logic                 w_rx_bit_end;
`ifdef UART_PARITY_EN
  logic                 r_rx_par_bad, w_rx_par_bad;
  logic                 r_parity_err, w_parity_err;
`endif

  assign w_rx_bit_end = w_tick && (r_rx_os == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    w_rx_state   = r_rx_state;
    w_rx_os      = r_rx_os;
    w_rx_bit     = r_rx_bit;
    w_rx_shift   = r_rx_shift;
    w_frame_err  = 1'b0;
    w_push       = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par_bad = r_rx_par_bad;
    w_parity_err = 1'b0;
`endif
    if (w_tick) w_rx_os = r_rx_os + OS_W'(1);
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_os = '0;
        if (w_tick && !r_rx_sync) w_rx_state = RX_START;
      end
      // Half-bit resample of the start bit rejects short glitches
      RX_START: begin
        if (w_tick && (r_rx_os == OS_W'(OVERSAMPLE / 2 - 1))) begin
          w_rx_os  = '0;
          w_rx_bit = '0;
`ifdef UART_PARITY_EN
          w_rx_par_bad = 1'b0;
`endif
          w_rx_state = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_bit_end) begin
          w_rx_os    = '0;
          w_rx_shift = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_rx_state = RX_PARITY;
`else
            w_rx_state = RX_STOP;
`endif
          end else begin
            w_rx_bit = r_rx_bit + BIT_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (w_rx_bit_end) begin
          w_rx_os      = '0;
          w_rx_par_bad = r_rx_sync ^ (^r_rx_shift) ^ bus.parity_odd;
          w_rx_state   = RX_STOP;
        end
      end
`endif
      // Stop sampled at midpoint; return to IDLE at once to catch back-to-back starts
      RX_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_os     = '0;
          w_rx_state  = RX_IDLE;
          w_frame_err = !r_rx_sync;
`ifdef UART_PARITY_EN
          w_parity_err = r_rx_par_bad;
          w_push       = r_rx_sync && !r_rx_par_bad;
`else
          w_push       = r_rx_sync;
`endif
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_os      <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_state   <= w_rx_state;
      r_rx_os      <= w_rx_os;
      r_rx_bit     <= w_rx_bit;
      r_rx_shift   <= w_rx_shift;
      r_frame_err  <= w_frame_err;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= w_rx_par_bad;
      r_parity_err <= w_parity_err;
`endif
    end
  end

  assign bus.rx_frame_err = r_frame_err;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = r_parity_err;
`endif

  uart_rx_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_rx_shift),
    .i_pop     (bus.rx_ready),
    .o_data    (bus.rx_data),
    .o_valid   (bus.rx_valid),
    .o_overrun (bus.rx_overrun)
  );

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
module tb_uart_core;
  localparam int unsigned DB       = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BIT_CLKS = 160;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;
  logic tx;
  logic dut_rx;

  assign dut_rx = loop_en ? tx : rx_drv;

  uart_if #(.DATA_BITS(DB)) bus ();

  uart_core #(
    .CLK_HZ        (1_600_000),
    .BAUD          (10_000),
    .OVERSAMPLE    (16),
    .DATA_BITS     (DB),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (dut_rx),
    .tx  (tx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  logic [7:0] exp_q [$];
`ifdef UART_PARITY_EN
  int n_perr   = 0;
  int exp_perr = 0;
`endif

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.rx_frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (bus.rx_overrun === 1'b1)   n_ovr  <= n_ovr + 1;
`ifdef UART_PARITY_EN
    if (bus.rx_parity_err === 1'b1) n_perr <= n_perr + 1;
`endif
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line-level frame: start, data LSB first, optional parity, stop
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    logic [FRAME_BITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_PARITY_EN
    f[9] = (^d) ^ bus.parity_odd;
`endif
    return f;
  endfunction

  task automatic rx_send_bits(input logic [FRAME_BITS-1:0] f);
    for (int i = 0; i < int'(FRAME_BITS); i++) begin
      rx_drv = f[i];
      step(int'(BIT_CLKS));
    end
    rx_drv = 1'b1;
  endtask

  task automatic model_rx(input logic [7:0] d, input logic good);
    if (!good)                            exp_ferr++;
    else if (exp_q.size() == int'(DEPTH)) exp_ovr++;
    else                                  exp_q.push_back(d);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    while (bus.rx_valid !== 1'b1 && t < 2000) begin
      step(1);
      t++;
    end
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check(tag, 32'(bus.rx_data), 32'(exp));
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
  endtask

  task automatic model_pop(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    pop_check(tag, e);
  endtask

  // Leaves the caller one clock after the acceptance edge
  task automatic tx_send(input logic [7:0] d);
    int t;
    t = 0;
    while (bus.tx_ready !== 1'b1 && t < 3000) begin
      step(1);
      t++;
    end
    check("tx_ready_wait", 32'(t < 3000), 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic tx_capture(input string tag, input logic [7:0] d);
    logic [FRAME_BITS-1:0] f;
    int off, t, len;
    f = build_frame(d);
    tx_send(d);
    check({tag, "_fall"}, 32'(tx), 32'd0);
    off = 0;
    for (int i = 0; i < int'(FRAME_BITS); i++) begin
      step(80 + 160 * i - off);
      off = 80 + 160 * i;
      check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(f[i]));
    end
    t = off;
    while (bus.tx_ready !== 1'b1 && t < 2500) begin
      step(1);
      t++;
    end
    len = int'(FRAME_BITS * BIT_CLKS);
    check({tag, "_busy_len"}, 32'(t >= len - 10 && t <= len + 10), 32'd1);
  endtask

  initial begin
    logic [FRAME_BITS-1:0] f;
    logic [7:0] d;
    logic good;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
`ifdef UART_PARITY_EN
    bus.parity_odd = 1'b0;
`endif

    // Reset values
    step(5);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_frame_err", 32'(bus.rx_frame_err), 32'd0);
    check("rst_overrun", 32'(bus.rx_overrun), 32'd0);
    rst = 1'b1;
    step(3);

    // Transmit 0xA5
    tx_capture("txA5", 8'hA5);

    // Loopback, two frames back to back
    loop_en = 1'b1;
    tx_send(8'h3C);
    model_rx(8'h3C, 1'b1);
    tx_send(8'hC3);
    model_rx(8'hC3, 1'b1);
    check("lb_valid_f1", 32'(bus.rx_valid), 32'd1);
    step(1800);
    model_pop("lb_pop0");
    model_pop("lb_pop1");
    check("lb_empty", 32'(bus.rx_valid), 32'd0);
    check("lb_ferr", 32'(n_ferr), 32'(exp_ferr));
    check("lb_ovr", 32'(n_ovr), 32'(exp_ovr));
    loop_en = 1'b0;
    step(50);

    // Start-bit glitch
    rx_drv = 1'b0;
    step(40);
    rx_drv = 1'b1;
    step(400);
    check("glitch_valid", 32'(bus.rx_valid), 32'd0);
    check("glitch_ferr", 32'(n_ferr), 32'(exp_ferr));
    rx_send_bits(build_frame(8'h5A));
    model_rx(8'h5A, 1'b1);
    model_pop("after_glitch");

    // Stop bit low
    f = build_frame(8'h55);
    f[FRAME_BITS-1] = 1'b0;
    rx_send_bits(f);
    model_rx(8'h55, 1'b0);
    step(300);
    check("ferr_count", 32'(n_ferr), 32'(exp_ferr));
    check("ferr_valid", 32'(bus.rx_valid), 32'd0);

    // Overrun: five frames into a four-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      rx_send_bits(build_frame(8'(k)));
      model_rx(8'(k), 1'b1);
      if (k == 4) check("ovr_before5", 32'(n_ovr), 32'(exp_ovr));
    end
    step(10);
    check("ovr_after5", 32'(n_ovr), 32'(exp_ovr));
    for (int k = 0; k < 4; k++) model_pop($sformatf("ovr_pop%0d", k));
    check("ovr_empty", 32'(bus.rx_valid), 32'd0);

    // Randomised receive frames against the queue model
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      f    = build_frame(d);
      if (!good) f[FRAME_BITS-1] = 1'b0;
      rx_send_bits(f);
      model_rx(d, good);
      step(good ? int'($urandom_range(0, 100)) : 300);
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
        model_pop($sformatf("rnd_pop%0d", k));
    end
    while (exp_q.size() > 0) model_pop("rnd_drain");
    check("rnd_empty", 32'(bus.rx_valid), 32'd0);
    check("rnd_ferr", 32'(n_ferr), 32'(exp_ferr));
    check("rnd_ovr", 32'(n_ovr), 32'(exp_ovr));

    // Randomised transmit bytes
    for (int k = 0; k < 3; k++) tx_capture($sformatf("txr%0d", k), 8'($urandom));

`ifdef UART_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    bus.parity_odd = 1'b0;
    f = build_frame(8'h07);
    f[9] = 1'b0;
    rx_send_bits(f);
    exp_perr++;
    step(300);
    check("par_err_count", 32'(n_perr), 32'(exp_perr));
    check("par_err_valid", 32'(bus.rx_valid), 32'd0);
    f = build_frame(8'h07);
    check("par_bit_model", 32'(f[9]), 32'(^8'h07));
    rx_send_bits(f);
    model_rx(8'h07, 1'b1);
    model_pop("par_ok");
    check("par_err_stable", 32'(n_perr), 32'(exp_perr));
`endif

    // Reset asserted mid-frame returns tx high at once
    tx_send(8'h00);
    step(300);
    check("midrst_tx_low", 32'(tx), 32'd0);
    rst = 1'b0;
    #2;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(bus.tx_ready), 32'd1);
    step(3);
    rst = 1'b1;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
